// File: rtl/xadc_pkg.sv
// Shared constants and state encoding for the TeachEE XADC DRP read sequencer.
package xadc_pkg;

  localparam logic [6:0]  XADC_CURRENT_ADDR = 7'h14;
  localparam logic [6:0]  XADC_VOLTAGE_ADDR = 7'h1c;
  localparam int unsigned XADC_RESULT_W     = 12;
  localparam int unsigned XADC_DRP_ADDR_W   = 7;
  localparam int unsigned XADC_DRP_DATA_W   = 16;

  typedef enum logic [2:0] {
    SeqIdle     = 3'd0,
    SeqReqCur   = 3'd1,
    SeqWaitCur  = 3'd2,
    SeqReqVolt  = 3'd3,
    SeqWaitVolt = 3'd4,
    SeqDeliver  = 3'd5
  } xadc_seq_state_t;

endpackage

// File: rtl/xadc_drp_sequencer_if.sv
// DRP port bundle between the sequencer (master) and the XADC or its BFM (slave).
interface xadc_drp_sequencer_if;
  import xadc_pkg::*;

  logic [XADC_DRP_ADDR_W-1:0] daddr_out;
  logic                       den_out;
  logic                       dwe_out;
  logic [XADC_DRP_DATA_W-1:0] di_out;
  logic                       drdy_in;
  logic [XADC_DRP_DATA_W-1:0] do_in;

  modport master (
    output daddr_out,
    output den_out,
    output dwe_out,
    output di_out,
    input  drdy_in,
    input  do_in
  );

  modport slave (
    input  daddr_out,
    input  den_out,
    input  dwe_out,
    input  di_out,
    output drdy_in,
    output do_in
  );

endinterface

// File: rtl/xadc_drp_sequencer.sv
// Reads the current then voltage XADC channels over DRP on each end-of-sequence pulse
// and presents them as one paired sample on a valid/ready output.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter logic [6:0]  CURRENT_ADDR   = XADC_CURRENT_ADDR,
  parameter logic [6:0]  VOLTAGE_ADDR   = XADC_VOLTAGE_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     dclk_in,
  input  logic                     reset_n_in,
  input  logic                     eos_in,
  xadc_drp_sequencer_if.master     drp,
  output logic [XADC_RESULT_W-1:0] current_sample_out,
  output logic [XADC_RESULT_W-1:0] voltage_sample_out,
  output logic                     sample_valid_out,
  input  logic                     sample_ready_in,
  output logic                     overrun_out,
  output logic                     timeout_out
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntTerm = CntW'(TIMEOUT_CYCLES);

  localparam logic [2:0] StIdle     = SeqIdle;
  localparam logic [2:0] StReqCur   = SeqReqCur;
  localparam logic [2:0] StWaitCur  = SeqWaitCur;
  localparam logic [2:0] StReqVolt  = SeqReqVolt;
  localparam logic [2:0] StWaitVolt = SeqWaitVolt;
  localparam logic [2:0] StDeliver  = SeqDeliver;

  logic [2:0]                 state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [6:0]                 daddr_q, daddr_d;
  logic                       den_q, den_d;
  logic [XADC_RESULT_W-1:0]   cur_cap_q, cur_cap_d;
  logic [XADC_RESULT_W-1:0]   volt_cap_q, volt_cap_d;
  logic [XADC_RESULT_W-1:0]   cur_out_q, cur_out_d;
  logic [XADC_RESULT_W-1:0]   volt_out_q, volt_out_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;
  logic                       timeout_q, timeout_d;
  logic                       unused_do_lsbs;

  // The XADC result is left-justified; the low nibble carries no conversion data.
  assign unused_do_lsbs = ^drp.do_in[3:0];

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    daddr_d    = '0;
    den_d      = 1'b0;
    cur_cap_d  = cur_cap_q;
    volt_cap_d = volt_cap_q;
    cur_out_d  = cur_out_q;
    volt_out_d = volt_out_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;

    if (valid_q && sample_ready_in) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (eos_in) begin
          state_d = StReqCur;
          den_d   = 1'b1;
          daddr_d = CURRENT_ADDR;
        end
      end
      StReqCur: begin
        cnt_d   = '0;
        state_d = StWaitCur;
      end
      StWaitCur: begin
        if (drp.drdy_in) begin
          cur_cap_d = drp.do_in[15:4];
          state_d   = StReqVolt;
          den_d     = 1'b1;
          daddr_d   = VOLTAGE_ADDR;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntTerm) begin
            timeout_d = 1'b1;
            cur_cap_d = '0;
            state_d   = StIdle;
          end
        end
      end
      StReqVolt: begin
        cnt_d   = '0;
        state_d = StWaitVolt;
      end
      StWaitVolt: begin
        if (drp.drdy_in) begin
          volt_cap_d = drp.do_in[15:4];
          state_d    = StDeliver;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntTerm) begin
            timeout_d  = 1'b1;
            cur_cap_d  = '0;
            volt_cap_d = '0;
            state_d    = StIdle;
          end
        end
      end
      StDeliver: begin
        state_d = StIdle;
        // A pending pair that is not being taken this cycle wins; the new pair is lost.
        if (valid_q && !sample_ready_in) begin
          overrun_d = 1'b1;
        end else begin
          cur_out_d  = cur_cap_q;
          volt_out_d = volt_cap_q;
          valid_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      daddr_q    <= '0;
      den_q      <= 1'b0;
      cur_cap_q  <= '0;
      volt_cap_q <= '0;
      cur_out_q  <= '0;
      volt_out_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      daddr_q    <= daddr_d;
      den_q      <= den_d;
      cur_cap_q  <= cur_cap_d;
      volt_cap_q <= volt_cap_d;
      cur_out_q  <= cur_out_d;
      volt_out_q <= volt_out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign drp.daddr_out = daddr_q;
  assign drp.den_out   = den_q;
  assign drp.dwe_out   = 1'b0;
  assign drp.di_out    = '0;

  assign current_sample_out = cur_out_q;
  assign voltage_sample_out = volt_out_q;
  assign sample_valid_out   = valid_q;
  assign overrun_out        = overrun_q;
  assign timeout_out        = timeout_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Randomised bench for xadc_drp_sequencer with an inline DRP responder and an
// event-timing reference model derived from the sequencing rules.
module tb_xadc_drp_sequencer;
  import xadc_pkg::*;

  localparam int unsigned T = 64;

  logic        dclk_in;
  logic        reset_n_in;
  logic        eos_in;
  logic [11:0] current_sample_out;
  logic [11:0] voltage_sample_out;
  logic        sample_valid_out;
  logic        sample_ready_in;
  logic        overrun_out;
  logic        timeout_out;

  xadc_drp_sequencer_if drp ();

  xadc_drp_sequencer #(
    .CURRENT_ADDR  (XADC_CURRENT_ADDR),
    .VOLTAGE_ADDR  (XADC_VOLTAGE_ADDR),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .dclk_in           (dclk_in),
    .reset_n_in        (reset_n_in),
    .eos_in            (eos_in),
    .drp               (drp),
    .current_sample_out(current_sample_out),
    .voltage_sample_out(voltage_sample_out),
    .sample_valid_out  (sample_valid_out),
    .sample_ready_in   (sample_ready_in),
    .overrun_out       (overrun_out),
    .timeout_out       (timeout_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Responder configuration
  logic [15:0] cur_word, volt_word;
  int          lat_cur = 1, lat_volt = 1;
  bit          mute_cur = 1'b0;

  // Observed events
  logic [6:0] den_addr[$];
  int         den_cyc[$];
  int         tmo_cyc[$];
  int         ovr_cnt = 0;
  bit         vld_seen = 1'b0;

  initial begin
    dclk_in = 1'b0;
    forever #5 dclk_in = ~dclk_in;
  end

  always @(posedge dclk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DRP responder: answers a den seen in cycle c with drdy during cycle c+latency.
  initial begin
    int          pend;
    logic [6:0]  pa;
    pend = 0;
    pa = '0;
    drp.drdy_in = 1'b0;
    drp.do_in   = '0;
    forever begin
      @(negedge dclk_in);
      drp.drdy_in = 1'b0;
      drp.do_in   = 16'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drp.drdy_in = 1'b1;
          drp.do_in   = (pa == XADC_CURRENT_ADDR) ? cur_word : volt_word;
        end
      end
      if (drp.den_out === 1'b1) begin
        pa   = drp.daddr_out;
        pend = (mute_cur && pa == XADC_CURRENT_ADDR) ? 0 :
               ((pa == XADC_CURRENT_ADDR) ? lat_cur : lat_volt);
      end
    end
  end

  initial begin
    forever begin
      @(negedge dclk_in);
      if (drp.den_out === 1'b1) begin
        den_addr.push_back(drp.daddr_out);
        den_cyc.push_back(cyc);
      end
      if (overrun_out === 1'b1) ovr_cnt++;
      if (timeout_out === 1'b1) tmo_cyc.push_back(cyc);
      if (sample_valid_out === 1'b1) vld_seen = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic pulse_eos(output int e);
    @(negedge dclk_in);
    eos_in = 1'b1;
    e = cyc;
    @(negedge dclk_in);
    eos_in = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int vc);
    vc = -1;
    for (int i = 0; i < budget; i++) begin
      if (sample_valid_out === 1'b1) begin
        vc = cyc;
        break;
      end
      @(negedge dclk_in);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge dclk_in);
  endtask

  // One full eos -> pair transaction; returns at the first cycle valid is seen.
  task automatic run_pair(input string tag, input logic [15:0] cw, input logic [15:0] vw,
                          input int l1, input int l2);
    int e, vc;
    cur_word = cw;
    volt_word = vw;
    lat_cur = l1;
    lat_volt = l2;
    den_addr.delete();
    den_cyc.delete();
    pulse_eos(e);
    wait_valid(2 * T + 40, vc);
    check({tag, "_vcyc"}, vc, e + 4 + l1 + l2);
    check({tag, "_cur"}, 32'(current_sample_out), 32'(cw[15:4]));
    check({tag, "_volt"}, 32'(voltage_sample_out), 32'(vw[15:4]));
    check({tag, "_nden"}, den_addr.size(), 2);
    check({tag, "_addr0"}, 32'(den_addr[0]), 32'(XADC_CURRENT_ADDR));
    check({tag, "_addr1"}, 32'(den_addr[1]), 32'(XADC_VOLTAGE_ADDR));
    check({tag, "_dcyc0"}, den_cyc[0], e + 1);
    check({tag, "_dcyc1"}, den_cyc[1], e + 2 + l1);
  endtask

  initial begin
    int e, d, hold;
    logic [15:0] cw, vw;
    reset_n_in = 1'b0;
    eos_in = 1'b0;
    sample_ready_in = 1'b1;
    cur_word = '0;
    volt_word = '0;
    repeat (3) @(negedge dclk_in);

    check("rst_den", 32'(drp.den_out), 0);
    check("rst_daddr", 32'(drp.daddr_out), 0);
    check("rst_dwe", 32'(drp.dwe_out), 0);
    check("rst_di", 32'(drp.di_out), 0);
    check("rst_valid", 32'(sample_valid_out), 0);
    check("rst_cur", 32'(current_sample_out), 0);
    check("rst_volt", 32'(voltage_sample_out), 0);
    check("rst_ovr", 32'(overrun_out), 0);
    check("rst_tmo", 32'(timeout_out), 0);
    reset_n_in = 1'b1;
    repeat (2) @(negedge dclk_in);

    run_pair("basic", 16'h8000, 16'h4000, 2, 3);
    @(negedge dclk_in);
    check("basic_vdrop", 32'(sample_valid_out), 0);

    for (int i = 0; i < 10; i++) begin
      cw = 16'($urandom);
      vw = 16'($urandom);
      hold = $urandom_range(0, 3);
      sample_ready_in = (hold == 0);
      run_pair("rnd", cw, vw, $urandom_range(1, 12), $urandom_range(1, 12));
      for (int k = 0; k < hold; k++) begin
        @(negedge dclk_in);
        check("rnd_hold_v", 32'(sample_valid_out), 1);
        check("rnd_hold_cur", 32'(current_sample_out), 32'(cw[15:4]));
        check("rnd_hold_volt", 32'(voltage_sample_out), 32'(vw[15:4]));
      end
      sample_ready_in = 1'b1;
      @(negedge dclk_in);
      check("rnd_vdrop", 32'(sample_valid_out), 0);
    end

    // Overrun: second pair completes while the first is still unaccepted
    sample_ready_in = 1'b0;
    ovr_cnt = 0;
    run_pair("ovrA", 16'h1230, 16'h4560, 3, 2);
    cur_word = 16'hABC0;
    volt_word = 16'hDEF0;
    pulse_eos(e);
    d = e + 3 + lat_cur + lat_volt;
    wait_until(d + 1);
    check("ovr_pulse", 32'(overrun_out), 1);
    check("ovr_valid", 32'(sample_valid_out), 1);
    check("ovr_cur_kept", 32'(current_sample_out), 32'h123);
    check("ovr_volt_kept", 32'(voltage_sample_out), 32'h456);
    @(negedge dclk_in);
    check("ovr_pulse_end", 32'(overrun_out), 0);
    sample_ready_in = 1'b1;
    @(negedge dclk_in);
    check("ovr_vdrop", 32'(sample_valid_out), 0);
    check("ovr_count", ovr_cnt, 1);

    // Accept of the old pair and commit of the new one in the same DELIVER cycle
    sample_ready_in = 1'b0;
    ovr_cnt = 0;
    run_pair("accA", 16'h1110, 16'h2220, 2, 4);
    cur_word = 16'h7770;
    volt_word = 16'h8880;
    pulse_eos(e);
    d = e + 3 + lat_cur + lat_volt;
    wait_until(d);
    check("acc_old_v", 32'(sample_valid_out), 1);
    sample_ready_in = 1'b1;
    @(negedge dclk_in);
    check("acc_new_v", 32'(sample_valid_out), 1);
    check("acc_new_cur", 32'(current_sample_out), 32'h777);
    check("acc_new_volt", 32'(voltage_sample_out), 32'h888);
    @(negedge dclk_in);
    check("acc_vdrop", 32'(sample_valid_out), 0);
    check("acc_no_ovr", ovr_cnt, 0);

    // Timeout on the current read
    tmo_cyc.delete();
    den_addr.delete();
    den_cyc.delete();
    vld_seen = 1'b0;
    mute_cur = 1'b1;
    pulse_eos(e);
    wait_until(e + T + 12);
    check("tmo_count", tmo_cyc.size(), 1);
    check("tmo_cyc", tmo_cyc[0], e + T + 2);
    check("tmo_nden", den_addr.size(), 1);
    check("tmo_no_valid", 32'(vld_seen), 0);
    mute_cur = 1'b0;
    run_pair("tmo_recover", 16'h5550, 16'h6660, 4, 4);

    // Responses arriving on the terminal count are successes
    tmo_cyc.delete();
    run_pair("edge_cur", 16'h0FF0, 16'hF000, T, 1);
    run_pair("edge_volt", 16'h0010, 16'hFFF0, 1, T);
    check("edge_no_tmo", tmo_cyc.size(), 0);

    // eos during WAIT_VOLT is dropped
    den_addr.delete();
    den_cyc.delete();
    cur_word = 16'h3210;
    volt_word = 16'h9870;
    lat_cur = 3;
    lat_volt = 10;
    pulse_eos(e);
    wait_until(e + lat_cur + 5);
    pulse_eos(d);
    wait_valid(60, d);
    check("wv_vcyc", d, e + 4 + 3 + 10);
    check("wv_cur", 32'(current_sample_out), 32'h321);
    repeat (20) @(negedge dclk_in);
    check("wv_nden", den_addr.size(), 2);

    // Asynchronous reset in the middle of a current read
    sample_ready_in = 1'b0;
    run_pair("rstA", 16'h4440, 16'h3330, 2, 2);
    den_addr.delete();
    pulse_eos(e);
    check("rst_mid_den_pre", 32'(drp.den_out), 1);
    reset_n_in = 1'b0;
    #1;
    check("rst_mid_den", 32'(drp.den_out), 0);
    check("rst_mid_daddr", 32'(drp.daddr_out), 0);
    check("rst_mid_valid", 32'(sample_valid_out), 0);
    repeat (3) @(negedge dclk_in);
    reset_n_in = 1'b1;
    sample_ready_in = 1'b1;
    repeat (20) @(negedge dclk_in);
    run_pair("rst_after", 16'hC0D0, 16'hE0F0, 2, 5);

    repeat (3) @(negedge dclk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
